mc_ctrl: RTL and testbench
==========================

Name: mc_ctrl

Overview:
Multi-cycle MIPS control FSM. Drives the ALU's ALUop/operand selects and the datapath strobes (PC, IR, memory, register file) for the multi-cycle CPU, one instruction over 3–5 states. Produces the `ALUop` codes the ALU consumes:
- 00: add
- 01: sub
- 10: decode from `func`

Takes `opcode` from the IR and `zero` from the ALU.

Parameters:
OP_R, 6'h00, R-type opcode
OP_LW, 6'h23, load word
OP_SW, 6'h2B, store word
OP_BEQ, 6'h04, branch if equal
OP_BNE, 6'h05, branch if not equal
OP_J, 6'h02, jump
OP_ADDI, 6'h08, add immediate

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
opcode  in  6  IR[31:26]; sampled only in ID
zero  in  1  ALU zero flag, combinational from ALU
mem_ready  in  1  memory completes access this cycle
state  out  4  current state code (debug)
pc_we  out  1  PC write enable = pc_write | (br_eq & zero) | (br_ne & ~zero)
iord  out  1  0 = PC addresses memory, 1 = ALUOut
mem_rd  out  1  memory read strobe
mem_wr  out  1  memory write strobe
ir_we  out  1  IR load
mem2reg  out  1  register write data: 0 = ALUOut, 1 = MDR
reg_dst  out  1  0 = rt, 1 = rd
reg_we  out  1  register file write
alu_src_a  out  1  0 = PC, 1 = rs register
alu_src_b  out  2  00 = B reg, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm << 2
alu_op  out  2  00 add, 01 sub, 10 func
pc_src  out  2  00 = ALU out, 01 = ALUOut, 10 = jump target
instr_done  out  1  one-cycle pulse on last state of each instruction
illegal  out  1  one-cycle pulse when ID sees an unknown opcode

Behaviour:
- Moore FSM, 4-bit state register; all outputs decoded from state. pc_we also depends on zero.
- Reset:
  - While rst = 1, state = IF (4'd0) and every strobe output is forced to 0: pc_we, mem_rd, mem_wr, ir_we, reg_we, instr_done, illegal.
  - Mux selects are don't-care but drive 0.
  - Reset mid-instruction abandons it with no partial write.
- States (code: asserted outputs -> next state):
  - IF (0): mem_rd, ir_we, alu_src_b = 01, alu_op = 00, pc_src = 00, pc_write gated by mem_ready. Stay in IF while !mem_ready; ir_we and pc_write are asserted only in the mem_ready cycle. -> ID.
  - ID (1): alu_src_b = 11, alu_op = 00 (branch target into ALUOut). Dispatch on opcode:
    - lw/sw -> MADR
    - R -> REX
    - beq/bne -> BR
    - j -> JMP
    - addi -> IEX
    - other -> IF, with illegal = 1 and instr_done = 1 this cycle
  - MADR (2): alu_src_a = 1, alu_src_b = 10, alu_op = 00. -> MRD if lw, MWR if sw (opcode held in IR).
  - MRD (3): iord = 1, mem_rd = 1. Wait on mem_ready. -> MWB.
  - MWB (4): reg_we, mem2reg = 1, reg_dst = 0, instr_done. -> IF.
  - MWR (5): iord = 1, mem_wr = 1. Wait on mem_ready. instr_done in the mem_ready cycle. -> IF.
  - REX (6): alu_src_a = 1, alu_src_b = 00, alu_op = 10. -> RWB.
  - RWB (7): reg_we, reg_dst = 1, mem2reg = 0, instr_done. -> IF.
  - BR (8): alu_src_a = 1, alu_src_b = 00, alu_op = 01, pc_src = 01.
    - br_eq is active for beq; br_ne for bne.
    - pc_we follows zero combinationally.
    - instr_done. -> IF.
  - JMP (9): pc_write, pc_src = 10, instr_done. -> IF.
  - IEX (10): alu_src_a = 1, alu_src_b = 10, alu_op = 00. -> IWB.
  - IWB (11): reg_we, reg_dst = 0, mem2reg = 0, instr_done. -> IF.
- Unused codes 12–15 -> IF next cycle, all strobes 0.
- mem_rd/mem_wr stay asserted for every wait cycle.
- mem_wr and reg_we are never both 1.
- Cycle counts with mem_ready tied to 1:
  - lw 5
  - sw 4
  - R 4
  - addi 4
  - beq/bne 3
  - j 3
  - illegal 2

Test Plan:
- rst = 1 asynchronously mid-clock while in MRD -> state = 0 immediately; mem_rd, reg_we, pc_we all 0. Release rst -> IF fetch on the next edge.
- mem_ready = 1, opcode = 6'h00 -> states 0,1,6,7,0:
  - alu_op = 10 in REX
  - reg_we = 1 and reg_dst = 1 only in RWB
  - instr_done pulses once
- opcode = 6'h23 with mem_ready low for 2 cycles in IF and 3 cycles in MRD:
  - IF lasts 3 cycles, ir_we only in the last one
  - MRD lasts 4 cycles
  - total 10 cycles; mem2reg = 1 in MWB
- opcode = 6'h04:
  - zero = 1 -> pc_we = 1, pc_src = 01, alu_op = 01 in BR
  - repeat with zero = 0 -> pc_we = 0
  - opcode = 6'h05 shows the inverse
- opcode = 6'h2B -> mem_wr = 1, iord = 1 in MWR, reg_we never 1 across the instruction. Then opcode = 6'h02 -> pc_we = 1, pc_src = 10 in state 9.
- opcode = 6'h3F -> illegal and instr_done pulse in ID, return to IF; no reg_we/mem_wr/pc_we beyond the fetch's PC+4.

Source files
------------

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute states and
// decodes every datapath strobe and mux select from the current state.
module mc_ctrl #(
  parameter logic [5:0] OP_R    = 6'h00,
  parameter logic [5:0] OP_LW   = 6'h23,
  parameter logic [5:0] OP_SW   = 6'h2B,
  parameter logic [5:0] OP_BEQ  = 6'h04,
  parameter logic [5:0] OP_BNE  = 6'h05,
  parameter logic [5:0] OP_J    = 6'h02,
  parameter logic [5:0] OP_ADDI = 6'h08
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic [3:0] state,
  output logic       pc_we,
  output logic       iord,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       ir_we,
  output logic       mem2reg,
  output logic       reg_dst,
  output logic       reg_we,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_src,
  output logic       instr_done,
  output logic       illegal
);

  typedef enum logic [3:0] {
    S_IF   = 4'd0,
    S_ID   = 4'd1,
    S_MADR = 4'd2,
    S_MRD  = 4'd3,
    S_MWB  = 4'd4,
    S_MWR  = 4'd5,
    S_REX  = 4'd6,
    S_RWB  = 4'd7,
    S_BR   = 4'd8,
    S_JMP  = 4'd9,
    S_IEX  = 4'd10,
    S_IWB  = 4'd11
  } state_t;

  state_t     state_q, state_d;
  logic [5:0] op_q, op_d;
  logic       pc_write;
  logic       br_eq;
  logic       br_ne;

  assign state = state_q;

  // opcode is captured in ID so later states do not depend on the live IR bus
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IF;
      op_q    <= 6'h00;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  always_comb begin
    state_d    = S_IF;
    op_d       = op_q;
    pc_write   = 1'b0;
    br_eq      = 1'b0;
    br_ne      = 1'b0;
    pc_we      = 1'b0;
    iord       = 1'b0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    ir_we      = 1'b0;
    mem2reg    = 1'b0;
    reg_dst    = 1'b0;
    reg_we     = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    pc_src     = 2'b00;
    instr_done = 1'b0;
    illegal    = 1'b0;
    if (rst) begin
      state_d = S_IF;
    end else begin
      case (state_q)
        S_IF: begin
          mem_rd    = 1'b1;
          alu_src_b = 2'b01;
          ir_we     = mem_ready;
          pc_write  = mem_ready;
          state_d   = mem_ready ? S_ID : S_IF;
        end
        S_ID: begin
          alu_src_b = 2'b11;
          op_d      = opcode;
          case (opcode)
            OP_LW, OP_SW:   state_d = S_MADR;
            OP_R:           state_d = S_REX;
            OP_BEQ, OP_BNE: state_d = S_BR;
            OP_J:           state_d = S_JMP;
            OP_ADDI:        state_d = S_IEX;
            default: begin
              illegal    = 1'b1;
              instr_done = 1'b1;
              state_d    = S_IF;
            end
          endcase
        end
        S_MADR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          state_d   = (op_q == OP_LW) ? S_MRD : S_MWR;
        end
        S_MRD: begin
          iord    = 1'b1;
          mem_rd  = 1'b1;
          state_d = mem_ready ? S_MWB : S_MRD;
        end
        S_MWB: begin
          reg_we     = 1'b1;
          mem2reg    = 1'b1;
          instr_done = 1'b1;
          state_d    = S_IF;
        end
        S_MWR: begin
          iord       = 1'b1;
          mem_wr     = 1'b1;
          instr_done = mem_ready;
          state_d    = mem_ready ? S_IF : S_MWR;
        end
        S_REX: begin
          alu_src_a = 1'b1;
          alu_op    = 2'b10;
          state_d   = S_RWB;
        end
        S_RWB: begin
          reg_we     = 1'b1;
          reg_dst    = 1'b1;
          instr_done = 1'b1;
          state_d    = S_IF;
        end
        S_BR: begin
          alu_src_a  = 1'b1;
          alu_op     = 2'b01;
          pc_src     = 2'b01;
          br_eq      = (op_q == OP_BEQ);
          br_ne      = (op_q == OP_BNE);
          instr_done = 1'b1;
          state_d    = S_IF;
        end
        S_JMP: begin
          pc_write   = 1'b1;
          pc_src     = 2'b10;
          instr_done = 1'b1;
          state_d    = S_IF;
        end
        S_IEX: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          state_d   = S_IWB;
        end
        S_IWB: begin
          reg_we     = 1'b1;
          instr_done = 1'b1;
          state_d    = S_IF;
        end
        default: state_d = S_IF;
      endcase
      // branch condition is resolved combinationally from the live ALU flag
      pc_we = pc_write | (br_eq & zero) | (br_ne & ~zero);
    end
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// Bench for mc_ctrl: per-instruction cycle scripts built from the state table,
// driven with random wait lengths and don't-care inputs.
module tb_mc_ctrl;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_ADDI = 6'h08;

  typedef struct packed {
    logic [3:0] st;
    logic       pc_we, iord, mem_rd, mem_wr, ir_we, mem2reg, reg_dst, reg_we, src_a;
    logic [1:0] src_b, alu_op, pc_src;
    logic       done, ill;
  } obs_t;

  logic       clk, rst, zero, mem_ready;
  logic [5:0] opcode;
  logic [3:0] state;
  logic       pc_we, iord, mem_rd, mem_wr, ir_we, mem2reg, reg_dst, reg_we, alu_src_a;
  logic [1:0] alu_src_b, alu_op, pc_src;
  logic       instr_done, illegal;
  int         total = 0;
  int         bad = 0;

  mc_ctrl dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .state(state), .pc_we(pc_we), .iord(iord), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .ir_we(ir_we), .mem2reg(mem2reg), .reg_dst(reg_dst), .reg_we(reg_we),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_src(pc_src),
    .instr_done(instr_done), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic rbit();
    int unsigned r;
    r = $urandom;
    return r[0];
  endfunction

  function automatic obs_t blank(input logic [3:0] st);
    obs_t o;
    o = '0;
    o.st = st;
    return o;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o = {state, pc_we, iord, mem_rd, mem_wr, ir_we, mem2reg, reg_dst, reg_we, alu_src_a,
         alu_src_b, alu_op, pc_src, instr_done, illegal};
    return o;
  endfunction

  task automatic check(input string tag, input obs_t exp);
    obs_t o;
    o = sample();
    total++;
    assert (o === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, o, exp);
    end
  endtask

  // Build the expected cycle-by-cycle script of one instruction, then play it.
  // zsel: 0/1 forces zero in the branch cycle, negative means random.
  task automatic run_instr(input logic [5:0] op, input int if_wait, input int mem_wait,
                           input int zsel, input int limit, input string tag);
    obs_t eq[$];
    logic mrq[$];
    logic zq[$];
    obs_t o;
    logic z;
    logic legal;
    legal = op inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_ADDI};
    for (int i = 0; i < if_wait; i++) begin
      o = blank(4'd0); o.mem_rd = 1'b1; o.src_b = 2'b01;
      eq.push_back(o); mrq.push_back(1'b0); zq.push_back(rbit());
    end
    o = blank(4'd0); o.mem_rd = 1'b1; o.ir_we = 1'b1; o.pc_we = 1'b1; o.src_b = 2'b01;
    eq.push_back(o); mrq.push_back(1'b1); zq.push_back(rbit());
    o = blank(4'd1); o.src_b = 2'b11;
    if (!legal) begin
      o.done = 1'b1; o.ill = 1'b1;
    end
    eq.push_back(o); mrq.push_back(rbit()); zq.push_back(rbit());
    if (op == OP_LW || op == OP_SW) begin
      o = blank(4'd2); o.src_a = 1'b1; o.src_b = 2'b10;
      eq.push_back(o); mrq.push_back(rbit()); zq.push_back(rbit());
      if (op == OP_LW) begin
        for (int i = 0; i <= mem_wait; i++) begin
          o = blank(4'd3); o.iord = 1'b1; o.mem_rd = 1'b1;
          eq.push_back(o); mrq.push_back(i == mem_wait); zq.push_back(rbit());
        end
        o = blank(4'd4); o.reg_we = 1'b1; o.mem2reg = 1'b1; o.done = 1'b1;
        eq.push_back(o); mrq.push_back(rbit()); zq.push_back(rbit());
      end else begin
        for (int i = 0; i <= mem_wait; i++) begin
          o = blank(4'd5); o.iord = 1'b1; o.mem_wr = 1'b1; o.done = (i == mem_wait);
          eq.push_back(o); mrq.push_back(i == mem_wait); zq.push_back(rbit());
        end
      end
    end else if (op == OP_R) begin
      o = blank(4'd6); o.src_a = 1'b1; o.alu_op = 2'b10;
      eq.push_back(o); mrq.push_back(rbit()); zq.push_back(rbit());
      o = blank(4'd7); o.reg_we = 1'b1; o.reg_dst = 1'b1; o.done = 1'b1;
      eq.push_back(o); mrq.push_back(rbit()); zq.push_back(rbit());
    end else if (op == OP_BEQ || op == OP_BNE) begin
      z = (zsel < 0) ? rbit() : (zsel != 0);
      o = blank(4'd8); o.src_a = 1'b1; o.alu_op = 2'b01; o.pc_src = 2'b01; o.done = 1'b1;
      o.pc_we = (op == OP_BEQ) ? z : ~z;
      eq.push_back(o); mrq.push_back(rbit()); zq.push_back(z);
    end else if (op == OP_J) begin
      o = blank(4'd9); o.pc_we = 1'b1; o.pc_src = 2'b10; o.done = 1'b1;
      eq.push_back(o); mrq.push_back(rbit()); zq.push_back(rbit());
    end else if (op == OP_ADDI) begin
      o = blank(4'd10); o.src_a = 1'b1; o.src_b = 2'b10;
      eq.push_back(o); mrq.push_back(rbit()); zq.push_back(rbit());
      o = blank(4'd11); o.reg_we = 1'b1; o.done = 1'b1;
      eq.push_back(o); mrq.push_back(rbit()); zq.push_back(rbit());
    end
    opcode = op;
    for (int i = 0; i < eq.size() && i < limit; i++) begin
      mem_ready = mrq[i];
      zero = zq[i];
      @(negedge clk);
      check(tag, eq[i]);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [5:0] ops [7];
    logic [5:0] op;
    ops = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_ADDI};
    rst = 1'b1; opcode = 6'h00; zero = 1'b1; mem_ready = 1'b1;
    @(negedge clk);
    check("reset", blank(4'd0));
    @(posedge clk);
    #1;
    rst = 1'b0;

    run_instr(OP_R,    0, 0, -1, 100, "rtype");
    run_instr(OP_LW,   2, 3, -1, 100, "lw_waits");
    run_instr(OP_BEQ,  0, 0,  1, 100, "beq_z1");
    run_instr(OP_BEQ,  0, 0,  0, 100, "beq_z0");
    run_instr(OP_BNE,  0, 0,  1, 100, "bne_z1");
    run_instr(OP_BNE,  0, 0,  0, 100, "bne_z0");
    run_instr(OP_SW,   0, 0, -1, 100, "sw");
    run_instr(OP_J,    0, 0, -1, 100, "jump");
    run_instr(6'h3F,   0, 0, -1, 100, "illegal");
    run_instr(OP_ADDI, 1, 0, -1, 100, "addi");

    // abandon a load while it waits in MRD
    run_instr(OP_LW, 0, 5, -1, 4, "lw_pre_rst");
    mem_ready = 1'b1;
    zero = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    check("rst_async", blank(4'd0));
    @(negedge clk);
    check("rst_hold", blank(4'd0));
    @(posedge clk);
    #1;
    check("rst_edge", blank(4'd0));
    rst = 1'b0;
    run_instr(OP_LW, 0, 0, -1, 100, "lw_after_rst");

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(7, 0) == 7) op = 6'($urandom);
      else op = ops[$urandom_range(6, 0)];
      run_instr(op, $urandom_range(3, 0), $urandom_range(3, 0), -1, 100, "random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
